io_port_responder: RTL and testbench

- Device-side responder for the processor's 16-bit I/O ports. It services the OUT direction by capturing every processor port write into a TX FIFO that drains to a host.
- It services the IN direction by queuing host-supplied words in an RX FIFO and presenting them on the processor's input port, one per processor read.
- It sits outside the processor, wired to portOut/portIn plus the IOW/IOR strobes taken from the memory-stage control bits.

---
 rtl/io_port_responder.sv | 107 ++++++++++
 tb/tb_io_port_responder.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_port_responder.sv
// Device-side responder for the processor's 16-bit I/O ports: a TX FIFO captures port
// writes for the host, and an RX FIFO feeds host words back to the processor's input port.
module io_port_responder #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cpu_iow,
   input  logic [WIDTH-1:0] cpu_port_out,
   input  logic             cpu_ior,
   output logic [WIDTH-1:0] cpu_port_in,
   output logic             host_tx_valid,
   output logic [WIDTH-1:0] host_tx_data,
   input  logic             host_tx_ready,
   input  logic             host_rx_valid,
   input  logic [WIDTH-1:0] host_rx_data,
   output logic             host_rx_ready,
   output logic [AW:0]      tx_count,
   output logic [AW:0]      rx_count,
   output logic             tx_overflow,
   output logic             rx_underflow,
   input  logic             flag_clr
);

   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] tx_mem_q [DEPTH];
   logic [WIDTH-1:0] rx_mem_q [DEPTH];

   logic [AW-1:0]    tx_wr_q, tx_wr_d, tx_rd_q, tx_rd_d;
   logic [AW-1:0]    rx_wr_q, rx_wr_d, rx_rd_q, rx_rd_d;
   logic [AW:0]      tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
   logic [WIDTH-1:0] last_q, last_d;
   logic             ovf_q, ovf_d, unf_q, unf_d;

   logic tx_push, tx_pop, rx_push, rx_pop;

   // Host handshakes: a word moves when valid and ready are both high at a rising edge;
   // valid never depends on ready, and host_tx_data holds steady while valid && !ready.
   always_comb begin
      tx_pop   = (tx_cnt_q != '0) && host_tx_ready;
      tx_push  = cpu_iow && ((tx_cnt_q != FULL) || tx_pop);
      rx_push  = host_rx_valid && (rx_cnt_q != FULL);
      rx_pop   = cpu_ior && (rx_cnt_q != '0);

      tx_wr_d  = tx_push ? tx_wr_q + AW'(1) : tx_wr_q;
      tx_rd_d  = tx_pop  ? tx_rd_q + AW'(1) : tx_rd_q;
      rx_wr_d  = rx_push ? rx_wr_q + AW'(1) : rx_wr_q;
      rx_rd_d  = rx_pop  ? rx_rd_q + AW'(1) : rx_rd_q;

      tx_cnt_d = tx_cnt_q;
      if (tx_push && !tx_pop) tx_cnt_d = tx_cnt_q + (AW+1)'(1);
      if (!tx_push && tx_pop) tx_cnt_d = tx_cnt_q - (AW+1)'(1);

      rx_cnt_d = rx_cnt_q;
      if (rx_push && !rx_pop) rx_cnt_d = rx_cnt_q + (AW+1)'(1);
      if (!rx_push && rx_pop) rx_cnt_d = rx_cnt_q - (AW+1)'(1);

      last_d   = rx_pop ? rx_mem_q[rx_rd_q] : last_q;

      // A fresh event in the same cycle as flag_clr keeps the flag set.
      ovf_d    = (cpu_iow && !tx_push) || (ovf_q && !flag_clr);
      unf_d    = (cpu_ior && (rx_cnt_q == '0)) || (unf_q && !flag_clr);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         tx_wr_q  <= '0;
         tx_rd_q  <= '0;
         rx_wr_q  <= '0;
         rx_rd_q  <= '0;
         tx_cnt_q <= '0;
         rx_cnt_q <= '0;
         last_q   <= '0;
         ovf_q    <= 1'b0;
         unf_q    <= 1'b0;
      end else begin
         tx_wr_q  <= tx_wr_d;
         tx_rd_q  <= tx_rd_d;
         rx_wr_q  <= rx_wr_d;
         rx_rd_q  <= rx_rd_d;
         tx_cnt_q <= tx_cnt_d;
         rx_cnt_q <= rx_cnt_d;
         last_q   <= last_d;
         ovf_q    <= ovf_d;
         unf_q    <= unf_d;
      end
   end

   // Storage is not reset; the counts alone decide which entries are live.
   always_ff @(posedge clk) begin
      if (!reset && tx_push) tx_mem_q[tx_wr_q] <= cpu_port_out;
      if (!reset && rx_push) rx_mem_q[rx_wr_q] <= host_rx_data;
   end

   assign host_tx_valid = (tx_cnt_q != '0);
   assign host_tx_data  = tx_mem_q[tx_rd_q];
   assign host_rx_ready = (rx_cnt_q != FULL);
   assign cpu_port_in   = (rx_cnt_q != '0) ? rx_mem_q[rx_rd_q] : last_q;
   assign tx_count      = tx_cnt_q;
   assign rx_count      = rx_cnt_q;
   assign tx_overflow   = ovf_q;
   assign rx_underflow  = unf_q;

endmodule

// File: tb/tb_io_port_responder.sv
// Directed bench for io_port_responder: queue-based reference model compared every cycle,
// a drain scoreboard of hand-listed TX words, and literal checks at the key points.
module tb_io_port_responder;

   localparam int W = 16;
   localparam int D = 8;

   logic         clk = 1'b0;
   logic         reset;
   logic         cpu_iow, cpu_ior, host_tx_ready, host_rx_valid, flag_clr;
   logic [W-1:0] cpu_port_out, host_rx_data;
   logic [W-1:0] cpu_port_in, host_tx_data;
   logic         host_tx_valid, host_rx_ready, tx_overflow, rx_underflow;
   logic [3:0]   tx_count, rx_count;

   int checks = 0;
   int errors = 0;
   bit en = 1'b0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_tx[$];
   logic [W-1:0] m_rx[$];
   logic [W-1:0] m_last;
   bit           m_ovf, m_unf;

   io_port_responder #(.WIDTH(W), .DEPTH(D), .AW(3)) dut (
      .clk(clk), .reset(reset),
      .cpu_iow(cpu_iow), .cpu_port_out(cpu_port_out),
      .cpu_ior(cpu_ior), .cpu_port_in(cpu_port_in),
      .host_tx_valid(host_tx_valid), .host_tx_data(host_tx_data), .host_tx_ready(host_tx_ready),
      .host_rx_valid(host_rx_valid), .host_rx_data(host_rx_data), .host_rx_ready(host_rx_ready),
      .tx_count(tx_count), .rx_count(rx_count),
      .tx_overflow(tx_overflow), .rx_underflow(rx_underflow), .flag_clr(flag_clr)
   );

   // clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: two word queues, a last-read word and two sticky bits.
   always @(posedge clk) begin
      if (reset) begin
         m_tx.delete();
         m_rx.delete();
         m_last = '0;
         m_ovf  = 1'b0;
         m_unf  = 1'b0;
      end else begin
         bit tpop, tpush, rpush, rpop, ovf_ev, unf_ev;
         tpop   = (m_tx.size() > 0) && host_tx_ready;
         tpush  = cpu_iow && ((m_tx.size() < D) || tpop);
         ovf_ev = cpu_iow && !tpush;
         rpush  = host_rx_valid && (m_rx.size() < D);
         rpop   = cpu_ior && (m_rx.size() > 0);
         unf_ev = cpu_ior && (m_rx.size() == 0);
         if (tpop) void'(m_tx.pop_front());
         if (tpush) m_tx.push_back(cpu_port_out);
         if (rpop) m_last = m_rx.pop_front();
         if (rpush) m_rx.push_back(host_rx_data);
         m_ovf = ovf_ev || (m_ovf && !flag_clr);
         m_unf = unf_ev || (m_unf && !flag_clr);
      end
   end

   // Every-cycle compare against the model, plus the TX drain scoreboard.
   always @(negedge clk) begin
      if (en) begin
         check("m_tx_count", 32'(tx_count), 32'(m_tx.size()));
         check("m_rx_count", 32'(rx_count), 32'(m_rx.size()));
         check("m_tx_valid", 32'(host_tx_valid), 32'(m_tx.size() != 0));
         if (m_tx.size() != 0) check("m_tx_data", 32'(host_tx_data), 32'(m_tx[0]));
         check("m_rx_ready", 32'(host_rx_ready), 32'(m_rx.size() < D));
         check("m_port_in", 32'(cpu_port_in), 32'((m_rx.size() != 0) ? m_rx[0] : m_last));
         check("m_tx_overflow", 32'(tx_overflow), 32'(m_ovf));
         check("m_rx_underflow", 32'(rx_underflow), 32'(m_unf));
         if (!reset && host_tx_valid && host_tx_ready) begin
            if (exp_q.size() == 0) check("tx_drain_extra", 32'(host_tx_data), 32'hFFFF_FFFF);
            else check("tx_drain_order", 32'(host_tx_data), 32'(exp_q.pop_front()));
         end
      end
   end

   // driver tasks
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      cpu_iow = 0; cpu_ior = 0; host_tx_ready = 0; host_rx_valid = 0; flag_clr = 0;
      cpu_port_out = '0; host_rx_data = '0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1;
      cyc();
      en = 1;
      cyc();
      reset = 0;
   endtask

   task automatic cpu_write(input logic [W-1:0] v);
      cpu_iow = 1; cpu_port_out = v;
      cyc();
      cpu_iow = 0;
   endtask

   task automatic host_push(input logic [W-1:0] v);
      host_rx_valid = 1; host_rx_data = v;
      cyc();
      host_rx_valid = 0;
   endtask

   task automatic cpu_read(input string name, input logic [W-1:0] v);
      cpu_ior = 1;
      #1;
      check(name, 32'(cpu_port_in), 32'(v));
      cyc();
      cpu_ior = 0;
   endtask

   task automatic drain(input int n);
      host_tx_ready = 1;
      repeat (n) cyc();
      host_tx_ready = 0;
   endtask

   initial begin
      do_reset();
      check("rst_tx_count", 32'(tx_count), 0);
      check("rst_tx_valid", 32'(host_tx_valid), 0);
      check("rst_rx_ready", 32'(host_rx_ready), 1);
      check("rst_port_in", 32'(cpu_port_in), 0);
      check("rst_flags", {30'd0, tx_overflow, rx_underflow}, 0);

      // 1: three writes held, then drained back to back
      cpu_write(16'h1111);
      check("t1_fwft_valid", 32'(host_tx_valid), 1);
      check("t1_fwft_data", 32'(host_tx_data), 32'h1111);
      cpu_write(16'h2222);
      cpu_write(16'h3333);
      check("t1_count", 32'(tx_count), 3);
      check("t1_head", 32'(host_tx_data), 32'h1111);
      exp_q.push_back(16'h1111); exp_q.push_back(16'h2222); exp_q.push_back(16'h3333);
      drain(3);
      check("t1_empty", 32'(host_tx_valid), 0);

      // 2: nine writes into eight slots
      for (int i = 1; i <= 9; i++) cpu_write(16'(i));
      check("t2_count", 32'(tx_count), 8);
      check("t2_overflow", 32'(tx_overflow), 1);
      for (int i = 1; i <= 8; i++) exp_q.push_back(16'(i));
      drain(8);
      check("t2_empty", 32'(host_tx_valid), 0);
      flag_clr = 1; cyc(); flag_clr = 0;
      check("t2_ovf_clr", 32'(tx_overflow), 0);

      // 3: push and pop in the same cycle while full
      for (int i = 0; i < 8; i++) cpu_write(16'h0100 + 16'(i));
      for (int i = 0; i <= 8; i++) exp_q.push_back(16'h0100 + 16'(i));
      cpu_iow = 1; cpu_port_out = 16'h0108; host_tx_ready = 1;
      cyc();
      cpu_iow = 0; host_tx_ready = 0;
      check("t3_count", 32'(tx_count), 8);
      check("t3_no_ovf", 32'(tx_overflow), 0);
      check("t3_head", 32'(host_tx_data), 32'h0101);
      drain(8);
      check("t3_empty", 32'(host_tx_valid), 0);

      // 4: two host words read by the processor
      host_push(16'hABCD);
      host_push(16'h1234);
      cpu_read("t4_read0", 16'hABCD);
      check("t4_next", 32'(cpu_port_in), 32'h1234);
      cpu_read("t4_read1", 16'h1234);
      check("t4_hold", 32'(cpu_port_in), 32'h1234);
      check("t4_rx_count", 32'(rx_count), 0);
      cyc();
      check("t4_hold2", 32'(cpu_port_in), 32'h1234);

      // 5: underflow after reset, and flag_clr losing to a new underflow
      do_reset();
      cpu_read("t5_port_in", 16'h0000);
      check("t5_unf", 32'(rx_underflow), 1);
      check("t5_port_hold", 32'(cpu_port_in), 0);
      flag_clr = 1; cpu_ior = 1; cyc(); flag_clr = 0; cpu_ior = 0;
      check("t5_unf_wins", 32'(rx_underflow), 1);
      flag_clr = 1; cyc(); flag_clr = 0;
      check("t5_unf_clr", 32'(rx_underflow), 0);
      host_rx_valid = 1; host_rx_data = 16'h5555; cpu_ior = 1;
      cyc();
      host_rx_valid = 0; cpu_ior = 0;
      check("t5_push_at_empty", 32'(rx_count), 1);
      check("t5_unf_push", 32'(rx_underflow), 1);
      check("t5_head", 32'(cpu_port_in), 32'h5555);
      host_rx_valid = 1; host_rx_data = 16'h6666; cpu_ior = 1;
      cyc();
      host_rx_valid = 0; cpu_ior = 0;
      check("t5_same_cycle", 32'(rx_count), 1);
      check("t5_head2", 32'(cpu_port_in), 32'h6666);

      // 6: fill, partial drain, refill across the wrap, then reset mid-sequence
      do_reset();
      for (int i = 0; i < 8; i++) host_push(16'hC000 + 16'(i));
      host_push(16'hDEAD);
      check("t6_full_ready", 32'(host_rx_ready), 0);
      check("t6_full_count", 32'(rx_count), 8);
      for (int i = 0; i < 3; i++) cpu_read("t6_pop_a", 16'hC000 + 16'(i));
      for (int i = 8; i < 11; i++) host_push(16'hC000 + 16'(i));
      check("t6_refill", 32'(rx_count), 8);
      for (int i = 3; i < 9; i++) cpu_read("t6_pop_b", 16'hC000 + 16'(i));
      check("t6_left", 32'(rx_count), 2);
      check("t6_head", 32'(cpu_port_in), 32'hC009);
      reset = 1; host_rx_valid = 1; host_rx_data = 16'hEEEE; cpu_ior = 1; cpu_iow = 1;
      cyc();
      reset = 0; host_rx_valid = 0; cpu_ior = 0; cpu_iow = 0;
      check("t6_rst_rx_count", 32'(rx_count), 0);
      check("t6_rst_tx_count", 32'(tx_count), 0);
      check("t6_rst_ready", 32'(host_rx_ready), 1);
      check("t6_rst_port_in", 32'(cpu_port_in), 0);
      cyc();

      check("tx_scoreboard_left", 32'(exp_q.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
